// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared sizes and reset constants for the decode-stage register
//               file and its pending-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int          DATA_W      = 32;
  localparam int          REG_COUNT   = 32;
  localparam int          REG_ADDR_W  = 5;
  localparam logic [31:0] SP_INIT     = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_INIT     = 32'h1000_8000;
  localparam int          MAX_PENDING = 3;
  localparam int          CNT_W       = 2;
  localparam logic [4:0]  ZERO_REG    = 5'd0;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/pending_counter.sv
`default_nettype none
// ============================================================================
// Module      : pending_counter
// Description : Saturating up/down count of writes issued but not yet written
//               back for one architectural register.
// Revision    : 1.0 - initial release
// ============================================================================
module pending_counter
  import rf_pkg::*;
#(
  parameter int MAX_PENDING = rf_pkg::MAX_PENDING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_PENDING);

  logic [CNT_W-1:0] r_count;
  logic             w_inc_only;
  logic             w_dec_only;

  assign w_inc_only = inc_i & ~dec_i;
  assign w_dec_only = dec_i & ~inc_i;

  // A simultaneous issue and writeback cancel out; the limits simply hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_inc_only && (r_count != C_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end else if (w_dec_only && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign count_o = r_count;
  assign sat_o   = (r_count == C_MAX);

endmodule : pending_counter
`default_nettype wire

// File: rtl/register_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : register_file_scoreboard
// Description : 32x32 RISC-V integer register file with write-to-read bypass
//               and per-register pending-write counters for RAW stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_scoreboard
  import rf_pkg::*;
#(
  parameter int          N           = rf_pkg::DATA_W,
  parameter int          REG_COUNT   = rf_pkg::REG_COUNT,
  parameter logic [31:0] SP_INIT     = rf_pkg::SP_INIT,
  parameter logic [31:0] GP_INIT     = rf_pkg::GP_INIT,
  parameter int          MAX_PENDING = rf_pkg::MAX_PENDING
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write_i,
  input  logic [REG_ADDR_W-1:0] write_register_i,
  input  logic [N-1:0]          write_data_i,
  input  logic [REG_ADDR_W-1:0] read_register_1_i,
  input  logic [REG_ADDR_W-1:0] read_register_2_i,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  output logic [N-1:0]          read_data_1_o,
  output logic [N-1:0]          read_data_2_o,
  output logic                  busy_1_o,
  output logic                  busy_2_o,
  output logic                  pending_overflow_o
);

  logic [N-1:0]         w_regs  [REG_COUNT];
  logic [CNT_W-1:0]     w_count [REG_COUNT];
  logic [REG_COUNT-1:0] w_ovf;
  logic                 r_overflow;

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
    if (i == 0) begin : g_zero
      // x0 is hardwired: no storage, never pending, never overflows.
      assign w_regs[i]  = '0;
      assign w_count[i] = '0;
      assign w_ovf[i]   = 1'b0;
    end else begin : g_cell
      localparam logic [N-1:0] C_INIT = (i == 2) ? N'(SP_INIT) :
                                        (i == 3) ? N'(GP_INIT) : '0;

      logic [N-1:0]     r_q;
      logic             w_wr_hit;
      logic             w_iss_hit;
      logic             w_sat;

      assign w_wr_hit  = reg_write_i   && (write_register_i == REG_ADDR_W'(i));
      assign w_iss_hit = issue_valid_i && (issue_rd_i       == REG_ADDR_W'(i));

      always_ff @(posedge clk) begin
        if (reset) begin
          r_q <= C_INIT;
        end else if (w_wr_hit) begin
          r_q <= write_data_i;
        end
      end

      pending_counter #(
        .MAX_PENDING (MAX_PENDING)
      ) u_pending (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (w_iss_hit),
        .dec_i   (w_wr_hit),
        .count_o (w_count[i]),
        .sat_o   (w_sat)
      );

      assign w_regs[i] = r_q;
      assign w_ovf[i]  = w_iss_hit & ~w_wr_hit & w_sat;
    end
  end

  always_comb begin
    read_data_1_o = w_regs[read_register_1_i];
    if (read_register_1_i == ZERO_REG) begin
      read_data_1_o = '0;
    end else if (reg_write_i && (write_register_i == read_register_1_i)) begin
      read_data_1_o = write_data_i;
    end
  end

  always_comb begin
    read_data_2_o = w_regs[read_register_2_i];
    if (read_register_2_i == ZERO_REG) begin
      read_data_2_o = '0;
    end else if (reg_write_i && (write_register_i == read_register_2_i)) begin
      read_data_2_o = write_data_i;
    end
  end

  // A writeback landing this cycle already retires one pending write.
  logic [CNT_W-1:0] w_cnt_1;
  logic [CNT_W-1:0] w_cnt_2;
  logic             w_hit_1;
  logic             w_hit_2;

  assign w_cnt_1  = w_count[read_register_1_i];
  assign w_cnt_2  = w_count[read_register_2_i];
  assign w_hit_1  = reg_write_i && (write_register_i == read_register_1_i) && (w_cnt_1 != '0);
  assign w_hit_2  = reg_write_i && (write_register_i == read_register_2_i) && (w_cnt_2 != '0);
  assign busy_1_o = (w_cnt_1 - CNT_W'(w_hit_1)) != '0;
  assign busy_2_o = (w_cnt_2 - CNT_W'(w_hit_2)) != '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (|w_ovf) begin
      r_overflow <= 1'b1;
    end
  end

  assign pending_overflow_o = r_overflow;

endmodule : register_file_scoreboard
`default_nettype wire
